threshold_sequencer: RTL and testbench

THRESHOLD_SEQUENCER -- requirements
Module: threshold_sequencer

---
 rtl/threshold_sequencer.sv | 166 ++++++++++++++++
 tb/tb_threshold_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/threshold_sequencer.sv
// -----------------------------------------------------------------------------
// threshold_sequencer
//
// Sequences an external registered thresholding unit. A configuration
// handshake loads a new threshold (one LOAD cycle with th_mode=1). Pixels are
// then streamed through th_byte one per cycle. The unit's registered result
// returns on th_result and is flagged with out_valid two edges after the
// pixel was accepted. frame_done marks the last result of each FRAME_LEN-pixel
// frame, and pass_count then reports how many nonzero results that frame had.
//
// Ports
//   clk            sole clock, rising edge
//   rst            synchronous active-high reset
//   cfg_valid      threshold-load request
//   cfg_threshold  threshold value to load
//   cfg_ready      load request accepted when cfg_valid && cfg_ready
//   pix_valid      pixel present
//   pix_data       pixel byte
//   pix_ready      pixel accepted when pix_valid && pix_ready
//   th_mode        to thresholding unit: 1 = load threshold, 0 = compare
//   th_byte        to thresholding unit: input byte
//   th_result      registered result from the thresholding unit
//   out_valid      out_data holds a valid thresholded pixel
//   out_data       thresholded pixel (pass-through of th_result)
//   frame_done     one-cycle pulse with the last out_valid of a frame
//   pass_count     nonzero results in the last completed frame
//   busy           high in any state other than IDLE
// -----------------------------------------------------------------------------
module threshold_sequencer #(
   parameter int unsigned FRAME_LEN = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_valid,
   input  logic [7:0]  cfg_threshold,
   output logic        cfg_ready,
   input  logic        pix_valid,
   input  logic [7:0]  pix_data,
   output logic        pix_ready,
   output logic        th_mode,
   output logic [7:0]  th_byte,
   input  logic [7:0]  th_result,
   output logic        out_valid,
   output logic [7:0]  out_data,
   output logic        frame_done,
   output logic [15:0] pass_count,
   output logic        busy
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] LOAD   = 2'd1;
   localparam logic [1:0] STREAM = 2'd2;
   localparam logic [1:0] DRAIN  = 2'd3;

   localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

   logic [1:0]  state;
   logic        loaded;
   logic [15:0] pix_cnt;
   logic [15:0] pass_acc;
   logic        v1;
   logic        last1;
   logic        cfg_acc;
   logic        pix_acc;
   logic        pix_last;
   logic        pass_inc;

   // Handshake readies. In IDLE a pending cfg blocks the pixel so that the
   // threshold load always wins a tie.
   always_comb begin
      cfg_ready = 1'b0;
      pix_ready = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: begin
               cfg_ready = 1'b1;
               pix_ready = loaded & ~cfg_valid;
            end
            STREAM:  pix_ready = 1'b1;
            default: ;
         endcase
      end
   end

   assign cfg_acc  = cfg_valid & cfg_ready;
   assign pix_acc  = pix_valid & pix_ready;
   assign pix_last = pix_acc && (pix_cnt == LAST_IDX);

   assign out_data = th_result;
   assign busy     = (state != IDLE);
   assign pass_inc = out_valid && (out_data != 8'h00);

   // Control FSM and the byte presented to the thresholding unit. The
   // threshold itself is not stored here: it travels on th_byte during LOAD
   // and the unit latches it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         loaded  <= 1'b0;
         th_mode <= 1'b0;
         th_byte <= '0;
         pix_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cfg_acc) begin
                  state   <= LOAD;
                  th_mode <= 1'b1;
                  th_byte <= cfg_threshold;
               end else if (pix_acc) begin
                  state <= pix_last ? DRAIN : STREAM;
               end
            end
            LOAD: begin
               th_mode <= 1'b0;
               loaded  <= 1'b1;
               state   <= STREAM;
            end
            STREAM: begin
               if (pix_last) state <= DRAIN;
            end
            DRAIN: begin
               if (frame_done) state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (pix_acc) begin
            th_byte <= pix_data;
            pix_cnt <= pix_last ? '0 : pix_cnt + 16'd1;
         end
      end
   end

   // Valid/last pipeline matching the unit's register: stage 1 covers the
   // cycle the pixel sits on th_byte, stage 2 the cycle its result is on
   // th_result.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1         <= 1'b0;
         last1      <= 1'b0;
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         v1         <= pix_acc;
         last1      <= pix_last;
         out_valid  <= v1;
         frame_done <= v1 & last1;
      end
   end

   // Pass accumulator; the frame_done cycle still carries the last result,
   // so it is folded into the published total.
   always_ff @(posedge clk) begin
      if (rst) begin
         pass_acc   <= '0;
         pass_count <= '0;
      end else if (frame_done) begin
         pass_count <= pass_acc + {15'd0, pass_inc};
         pass_acc   <= '0;
      end else begin
         pass_acc <= pass_acc + {15'd0, pass_inc};
      end
   end

endmodule

// File: tb/tb_threshold_sequencer.sv
// -----------------------------------------------------------------------------
// tb_threshold_sequencer
//
// Three sequencer instances (FRAME_LEN 4, 64 and 1), each paired with a
// behavioural thresholding unit (result = byte if byte > threshold, else 0).
// A transaction-level reference model predicts handshakes, results, frame
// boundaries and pass counts every cycle.
// -----------------------------------------------------------------------------
module tb_threshold_sequencer;

   function automatic int fl_of(input int i);
      return (i == 0) ? 4 : (i == 1) ? 64 : 1;
   endfunction

   logic clk;
   logic       rst           [3];
   logic       cfg_valid     [3];
   logic [7:0] cfg_threshold [3];
   logic       cfg_ready     [3];
   logic       pix_valid     [3];
   logic [7:0] pix_data      [3];
   logic       pix_ready     [3];
   logic       th_mode       [3];
   logic [7:0] th_byte       [3];
   logic [7:0] th_result     [3];
   logic       out_valid     [3];
   logic [7:0] out_data      [3];
   logic       frame_done    [3];
   logic [15:0] pass_count   [3];
   logic       busy          [3];
   logic [7:0] thr_u         [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned FLV = fl_of(g);
      threshold_sequencer #(.FRAME_LEN(FLV)) dut (
         .clk           (clk),
         .rst           (rst[g]),
         .cfg_valid     (cfg_valid[g]),
         .cfg_threshold (cfg_threshold[g]),
         .cfg_ready     (cfg_ready[g]),
         .pix_valid     (pix_valid[g]),
         .pix_data      (pix_data[g]),
         .pix_ready     (pix_ready[g]),
         .th_mode       (th_mode[g]),
         .th_byte       (th_byte[g]),
         .th_result     (th_result[g]),
         .out_valid     (out_valid[g]),
         .out_data      (out_data[g]),
         .frame_done    (frame_done[g]),
         .pass_count    (pass_count[g]),
         .busy          (busy[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural thresholding units
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst[i]) begin
            thr_u[i]     <= 8'h00;
            th_result[i] <= 8'h00;
         end else begin
            if (th_mode[i]) thr_u[i] <= th_byte[i];
            th_result[i] <= (th_byte[i] > thr_u[i]) ? th_byte[i] : 8'h00;
         end
      end
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic string tg(input int i, input string s);
      return $sformatf("d%0d.%s", i, s);
   endfunction

   // Reference model state
   typedef struct {
      logic [7:0] val;
      int         due;
      bit         last;
      int         nz;
   } pend_t;

   pend_t       pq [3][$];
   bit          m_loaded [3];
   bit          m_ld     [3];
   bit          m_infr   [3];
   bit          m_drain  [3];
   bit          m_pacc   [3];
   bit          m_cacc   [3];
   int          m_fcnt   [3];
   int          m_fnz    [3];
   logic [15:0] m_pass   [3];
   logic [7:0]  m_thr    [3];
   logic [7:0]  m_thb    [3];
   int          obs_ov [3];
   int          obs_fd [3];
   int          obs_cr [3];
   int          obs_tm [3];
   int          cyc = 0;

   task automatic model_reset(input int i);
      m_loaded[i] = 0; m_ld[i] = 0; m_infr[i] = 0; m_drain[i] = 0;
      m_fcnt[i] = 0; m_fnz[i] = 0; m_pass[i] = '0; m_thb[i] = '0;
      m_thr[i] = '0; m_pacc[i] = 0; m_cacc[i] = 0;
      pq[i].delete();
   endtask

   task automatic clr_obs(input int i);
      obs_ov[i] = 0; obs_fd[i] = 0; obs_cr[i] = 0; obs_tm[i] = 0;
   endtask

   task automatic model_cycle(input int i);
      bit ecr, epr, eov, efd;
      pend_t e;
      ecr = !rst[i] && !m_ld[i] && !m_drain[i] && !m_infr[i];
      epr = !rst[i] && !m_ld[i] && !m_drain[i] &&
            (m_infr[i] || (m_loaded[i] && !cfg_valid[i]));
      eov = (pq[i].size() > 0) && (pq[i][0].due == cyc);
      efd = eov && pq[i][0].last;

      chk(tg(i, "cfg_ready"),  cfg_ready[i],  ecr);
      chk(tg(i, "pix_ready"),  pix_ready[i],  epr);
      chk(tg(i, "out_valid"),  out_valid[i],  eov);
      chk(tg(i, "frame_done"), frame_done[i], efd);
      chk(tg(i, "th_mode"),    th_mode[i],    m_ld[i]);
      chk(tg(i, "th_byte"),    th_byte[i],    m_thb[i]);
      chk(tg(i, "busy"),       busy[i],       m_ld[i] || m_infr[i] || m_drain[i]);
      chk(tg(i, "pass_count"), pass_count[i], m_pass[i]);
      if (eov) chk(tg(i, "out_data"), out_data[i], pq[i][0].val);

      if (out_valid[i] === 1'b1)  obs_ov[i]++;
      if (frame_done[i] === 1'b1) obs_fd[i]++;
      if (cfg_ready[i] === 1'b1)  obs_cr[i]++;
      if (th_mode[i] === 1'b1)    obs_tm[i]++;

      if (eov) begin
         e = pq[i].pop_front();
         if (e.last) begin
            m_drain[i] = 0;
            m_pass[i]  = 16'(e.nz);
         end
      end

      if (rst[i]) begin
         model_reset(i);
      end else begin
         m_cacc[i] = cfg_valid[i] && ecr;
         m_pacc[i] = pix_valid[i] && epr;
         if (m_ld[i]) begin
            m_loaded[i] = 1;
            m_infr[i]   = 1;
         end
         if (m_cacc[i]) begin
            m_thr[i] = cfg_threshold[i];
            m_thb[i] = cfg_threshold[i];
         end
         if (m_pacc[i]) begin
            m_thb[i] = pix_data[i];
            m_fcnt[i]++;
            if (pix_data[i] > m_thr[i]) m_fnz[i]++;
            e.val  = (pix_data[i] > m_thr[i]) ? pix_data[i] : 8'h00;
            e.due  = cyc + 2;
            e.last = (m_fcnt[i] == fl_of(i));
            e.nz   = m_fnz[i];
            pq[i].push_back(e);
            if (e.last) begin
               m_infr[i]  = 0;
               m_drain[i] = 1;
               m_fcnt[i]  = 0;
               m_fnz[i]   = 0;
            end else begin
               m_infr[i] = 1;
            end
         end
         m_ld[i] = m_cacc[i];
      end
   endtask

   // One clock: check at the falling edge, then return just after the
   // following rising edge so the caller can drive the next inputs.
   task automatic tick();
      @(negedge clk);
      for (int i = 0; i < 3; i++) model_cycle(i);
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic send_pix(input int i, input logic [7:0] p);
      bit ok;
      ok = 0;
      pix_valid[i] = 1'b1;
      pix_data[i]  = p;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (m_pacc[i]) begin
            ok = 1;
            break;
         end
      end
      chk(tg(i, "pix_accept"), {31'd0, ok}, 32'd1);
   endtask

   task automatic do_cfg(input int i, input logic [7:0] t);
      bit ok;
      ok = 0;
      cfg_valid[i]     = 1'b1;
      cfg_threshold[i] = t;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (m_cacc[i]) begin
            ok = 1;
            break;
         end
      end
      cfg_valid[i] = 1'b0;
      chk(tg(i, "cfg_accept"), {31'd0, ok}, 32'd1);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] v44 [4];
      logic [7:0] v45 [3];
      v44 = '{8'h10, 8'h81, 8'hFF, 8'h80};
      v45 = '{8'h05, 8'h21, 8'h20};

      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1; cfg_valid[i] = 1'b0; cfg_threshold[i] = '0;
         pix_valid[i] = 1'b0; pix_data[i] = '0;
         model_reset(i);
         clr_obs(i);
      end
      repeat (2) @(posedge clk);
      #1;
      idle(2);
      for (int i = 0; i < 3; i++) rst[i] = 1'b0;

      // No threshold loaded yet: pixels must be refused
      clr_obs(0);
      pix_valid[0] = 1'b1;
      pix_data[0]  = 8'h55;
      idle(10);
      pix_valid[0] = 1'b0;
      chk("d0.no_out_unloaded", obs_ov[0], 0);

      // Threshold 0x80, one 4-pixel frame back to back
      do_cfg(0, 8'h80);
      for (int k = 0; k < 4; k++) send_pix(0, v44[k]);
      pix_valid[0] = 1'b0;
      idle(4);
      chk("d0.pass_frame44", pass_count[0], 2);

      // cfg and pixel together in IDLE: load wins, pixel waits
      clr_obs(0);
      cfg_valid[0]     = 1'b1;
      cfg_threshold[0] = 8'h20;
      pix_valid[0]     = 1'b1;
      pix_data[0]      = 8'h90;
      tick();
      chk("d0.cfg_wins", {31'd0, m_cacc[0]}, 32'd1);
      cfg_valid[0] = 1'b0;
      send_pix(0, 8'h90);
      for (int k = 0; k < 3; k++) send_pix(0, v45[k]);
      pix_valid[0] = 1'b0;
      idle(4);
      chk("d0.th_mode_once", obs_tm[0], 1);
      chk("d0.pass_frame45", pass_count[0], 2);

      // Randomized traffic, with occasional resets
      for (int k = 0; k < 400; k++) begin
         cfg_valid[0]     = ($urandom_range(0, 7) == 0);
         cfg_threshold[0] = 8'($urandom);
         pix_valid[0]     = ($urandom_range(0, 3) != 0);
         pix_data[0]      = 8'($urandom);
         rst[0]           = ($urandom_range(0, 79) == 0);
         tick();
      end
      rst[0] = 1'b0; cfg_valid[0] = 1'b0; pix_valid[0] = 1'b0;
      idle(4);

      // 64-pixel frame with pix_valid toggling 1,0,0
      do_cfg(1, 8'($urandom));
      clr_obs(1);
      for (int k = 0; k < 64; k++) begin
         send_pix(1, 8'($urandom));
         pix_valid[1] = 1'b0;
         tick();
         tick();
      end
      chk("d1.cfg_ready_in_frame", obs_cr[1], 0);
      idle(3);
      chk("d1.out_valid_count", obs_ov[1], 64);
      chk("d1.frame_done_count", obs_fd[1], 1);

      // Reset after pixel 10 of a frame
      for (int k = 0; k < 10; k++) send_pix(1, 8'($urandom));
      pix_valid[1] = 1'b0;
      rst[1] = 1'b1;
      tick();
      rst[1] = 1'b0;
      clr_obs(1);
      tick();
      chk("d1.rst_busy", busy[1], 0);
      chk("d1.rst_out_valid", out_valid[1], 0);
      chk("d1.rst_th_byte", th_byte[1], 0);
      chk("d1.rst_pass", pass_count[1], 0);
      pix_valid[1] = 1'b1;
      idle(6);
      pix_valid[1] = 1'b0;
      chk("d1.rst_no_out", obs_ov[1], 0);
      chk("d1.rst_no_fd", obs_fd[1], 0);

      // FRAME_LEN=1: every pixel is its own frame
      clr_obs(2);
      do_cfg(2, 8'h00);
      send_pix(2, 8'h00);
      pix_valid[2] = 1'b0;
      idle(4);
      chk("d2.pass_first", pass_count[2], 0);
      send_pix(2, 8'h01);
      pix_valid[2] = 1'b0;
      idle(4);
      chk("d2.pass_second", pass_count[2], 1);
      chk("d2.frames", obs_fd[2], 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
